// File: rtl/instr_prefetch_if.sv
// Signal bundle for instr_prefetch: core-side instruction handshake plus the
// Avalon-MM read master towards instruction memory.
interface instr_prefetch_if;
  logic        ins_valid;
  logic [31:0] ins_data;
  logic [31:0] ins_pc;
  logic        ins_ready;
  logic [31:0] avm_address;
  logic        avm_read;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        avm_waitrequest;

  modport master (
    output ins_valid, ins_data, ins_pc, avm_address, avm_read, avm_byteenable,
    input  ins_ready, avm_readdata, avm_readdatavalid, avm_waitrequest
  );

  modport slave (
    input  ins_valid, ins_data, ins_pc, avm_address, avm_read, avm_byteenable,
    output ins_ready, avm_readdata, avm_readdatavalid, avm_waitrequest
  );
endinterface

// File: rtl/instr_prefetch.sv
// Instruction prefetch: credit-limited pipelined Avalon-MM word reads into a
// small {pc,data} FIFO, with redirect flush and in-flight response discard.
module instr_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  instr_prefetch_if.master bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned DW = 16;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef enum logic {REQ_LIVE, REQ_STALE} req_state_e;

  req_state_e    state_q, state_d;
  logic [31:0]   stale_addr_q, stale_addr_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   fifo_pc_q [DEPTH];
  logic [31:0]   fifo_pc_d [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];
  logic [31:0]   fifo_data_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [DW-1:0] discard_q, discard_d;
  logic [31:0]   rq_pc_q [DEPTH];
  logic [31:0]   rq_pc_d [DEPTH];
  logic [PW-1:0] rq_wr_q, rq_wr_d, rq_rd_q, rq_rd_d;

  logic        credit_ok, avm_read, ins_valid;
  logic [31:0] avm_address, redirect_aligned;
  logic        accept, live_accept, stale_accept, keep, drop, consume;

  always_comb begin
    credit_ok        = ({1'b0, count_q} + {1'b0, outstanding_q}) < DEPTH_C;
    // A request stalled across a redirect stays on the bus with its old address.
    avm_read         = !rst && ((state_q == REQ_STALE) || credit_ok);
    avm_address      = (state_q == REQ_STALE) ? stale_addr_q : fetch_pc_q;
    ins_valid        = (count_q != '0);
    redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

    accept       = avm_read && !bus.avm_waitrequest;
    live_accept  = accept && (state_q == REQ_LIVE);
    stale_accept = accept && (state_q == REQ_STALE);
    drop         = bus.avm_readdatavalid && (discard_q != '0);
    keep         = bus.avm_readdatavalid && (discard_q == '0);
    consume      = ins_valid && bus.ins_ready;

    bus.avm_read       = avm_read;
    bus.avm_address    = avm_address;
    bus.avm_byteenable = '1;
    bus.ins_valid      = ins_valid;
    bus.ins_pc         = ins_valid ? fifo_pc_q[rd_ptr_q]   : '0;
    bus.ins_data       = ins_valid ? fifo_data_q[rd_ptr_q] : '0;
  end

  always_comb begin
    state_d       = state_q;
    stale_addr_d  = stale_addr_q;
    fetch_pc_d    = fetch_pc_q;
    fifo_pc_d     = fifo_pc_q;
    fifo_data_d   = fifo_data_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    rq_pc_d       = rq_pc_q;
    rq_wr_d       = rq_wr_q;
    rq_rd_d       = rq_rd_q;

    if (redirect) begin
      // Everything in flight (plus a same-cycle acceptance) becomes discard;
      // a same-cycle response is dropped and removed from the total.
      count_d       = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      rq_wr_d       = '0;
      rq_rd_d       = '0;
      outstanding_d = '0;
      discard_d     = discard_q + DW'(outstanding_q) + DW'(accept)
                      - DW'(bus.avm_readdatavalid);
      fetch_pc_d    = redirect_aligned;
      state_d       = (avm_read && bus.avm_waitrequest) ? REQ_STALE : REQ_LIVE;
      stale_addr_d  = avm_address;
    end else begin
      if (live_accept) begin
        fetch_pc_d       = fetch_pc_q + 32'd4;
        rq_pc_d[rq_wr_q] = fetch_pc_q;
        rq_wr_d          = rq_wr_q + PW'(1);
      end
      if (stale_accept) begin
        state_d = REQ_LIVE;
      end
      if (keep) begin
        fifo_pc_d[wr_ptr_q]   = rq_pc_q[rq_rd_q];
        fifo_data_d[wr_ptr_q] = bus.avm_readdata;
        wr_ptr_d              = wr_ptr_q + PW'(1);
        rq_rd_d               = rq_rd_q + PW'(1);
      end
      if (consume) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      discard_d     = discard_q + DW'(stale_accept) - DW'(drop);
      outstanding_d = outstanding_q + CW'(live_accept) - CW'(keep);
      count_d       = count_q + CW'(keep) - CW'(consume);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= REQ_LIVE;
      stale_addr_q  <= '0;
      fetch_pc_q    <= RESET_PC;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      rq_wr_q       <= '0;
      rq_rd_q       <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_pc_q[i]   <= '0;
        fifo_data_q[i] <= '0;
        rq_pc_q[i]     <= '0;
      end
    end else begin
      state_q       <= state_d;
      stale_addr_q  <= stale_addr_d;
      fetch_pc_q    <= fetch_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      rq_wr_q       <= rq_wr_d;
      rq_rd_q       <= rq_rd_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_pc_q[i]   <= fifo_pc_d[i];
        fifo_data_q[i] <= fifo_data_d[i];
        rq_pc_q[i]     <= rq_pc_d[i];
      end
    end
  end
endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch: in-order memory model with configurable
// latency and waitrequest, consumed words checked against an expected PC stream.
module tb_instr_prefetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DATA_KEY = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  instr_prefetch_if bus_if ();

  instr_prefetch #(
    .DEPTH    (4),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus_if)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          lat      = 1;
  int          cyc      = 0;
  int          n_cons   = 0;
  int          n0;
  logic [31:0] exp_pc   = RESET_PC;
  logic [31:0] pipe_addr [$];
  int          pipe_due  [$];
  logic [31:0] acc_log   [$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] log_at(input int idx);
    return (idx < acc_log.size()) ? acc_log[idx] : 32'hDEAD_BEEF;
  endfunction

  // One clock: note handshakes before the edge, then advance the memory model.
  task automatic tick();
    logic        acc, stalled;
    logic [31:0] addr;
    acc     = bus_if.avm_read && !bus_if.avm_waitrequest;
    stalled = bus_if.avm_read && bus_if.avm_waitrequest;
    addr    = bus_if.avm_address;
    if (bus_if.ins_valid && bus_if.ins_ready) begin
      check_eq("ins_pc", bus_if.ins_pc, exp_pc);
      check_eq("ins_data", bus_if.ins_data, exp_pc ^ DATA_KEY);
      exp_pc = exp_pc + 32'd4;
      n_cons++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (stalled) begin
      check_eq("stall_read_held", bus_if.avm_read, 1);
      check_eq("stall_addr_held", bus_if.avm_address, addr);
    end
    if (acc) begin
      acc_log.push_back(addr);
      pipe_addr.push_back(addr);
      pipe_due.push_back(cyc + lat - 1);
    end
    if (pipe_due.size() > 0 && pipe_due[0] <= cyc) begin
      bus_if.avm_readdatavalid = 1'b1;
      bus_if.avm_readdata      = pipe_addr[0] ^ DATA_KEY;
      void'(pipe_addr.pop_front());
      void'(pipe_due.pop_front());
    end else begin
      bus_if.avm_readdatavalid = 1'b0;
      bus_if.avm_readdata      = '0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic apply_reset();
    rst                      = 1'b1;
    redirect                 = 1'b0;
    bus_if.avm_waitrequest   = 1'b0;
    bus_if.avm_readdatavalid = 1'b0;
    bus_if.avm_readdata      = '0;
    pipe_addr.delete();
    pipe_due.delete();
    #2;
    check_eq("rst_avm_read", bus_if.avm_read, 0);
    check_eq("rst_avm_address", bus_if.avm_address, RESET_PC);
    check_eq("rst_byteenable", bus_if.avm_byteenable, 32'hF);
    check_eq("rst_ins_valid", bus_if.ins_valid, 0);
    check_eq("rst_ins_data", bus_if.ins_data, 0);
    check_eq("rst_ins_pc", bus_if.ins_pc, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    acc_log.delete();
    exp_pc = RESET_PC;
    cyc    = 0;
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] pc, input logic [31:0] target);
    redirect    = 1'b1;
    redirect_pc = pc;
    tick();
    redirect    = 1'b0;
    redirect_pc = '0;
    exp_pc      = target;
  endtask

  initial begin
    bus_if.ins_ready       = 1'b1;
    bus_if.avm_waitrequest = 1'b0;

    // Zero-wait memory, core always ready: 0,4,8,... at one per cycle.
    lat = 1;
    apply_reset();
    check_eq("t1_first_read", bus_if.avm_read, 1);
    check_eq("t1_valid_c0", bus_if.ins_valid, 0);
    tick();
    check_eq("t1_valid_c1", bus_if.ins_valid, 0);
    tick();
    check_eq("t1_valid_c2", bus_if.ins_valid, 1);
    n0 = n_cons;
    for (int i = 0; i < 12; i++) begin
      tick();
      check_eq("t1_fullrate", bus_if.ins_valid, 1);
    end
    check_eq("t1_consumed", n_cons - n0, 12);

    // Core stalled: exactly DEPTH reads, then resume at 0x10 after drain.
    bus_if.ins_ready = 1'b0;
    apply_reset();
    run(20);
    check_eq("t2_accepts", acc_log.size(), 4);
    check_eq("t2_read_low", bus_if.avm_read, 0);
    check_eq("t2_head_pc", bus_if.ins_pc, 32'h0);
    bus_if.ins_ready = 1'b1;
    n0 = n_cons;
    run(10);
    check_eq("t2_resume_addr", log_at(4), 32'h10);
    check_eq("t2_drained", (n_cons - n0) >= 4, 1);

    // 3-cycle latency, redirect with reads in flight: stale data dropped.
    bus_if.ins_ready = 1'b0;
    lat = 3;
    apply_reset();
    run(2);
    check_eq("t3_inflight", acc_log.size(), 2);
    do_redirect(32'h0000_0100, 32'h0000_0100);
    check_eq("t3_redir_addr", bus_if.avm_address, 32'h100);
    check_eq("t3_redir_read", bus_if.avm_read, 1);
    check_eq("t3_redir_valid", bus_if.ins_valid, 0);
    bus_if.ins_ready = 1'b1;
    n0 = n_cons;
    run(15);
    check_eq("t3_progress", (n_cons - n0) >= 3, 1);

    // Redirect while a read of 0x8 is stalled on waitrequest.
    lat = 1;
    apply_reset();
    run(2);
    bus_if.avm_waitrequest = 1'b1;
    tick();
    check_eq("t4_stall_addr", bus_if.avm_address, 32'h8);
    do_redirect(32'h0000_0200, 32'h0000_0200);
    check_eq("t4_held_addr", bus_if.avm_address, 32'h8);
    check_eq("t4_held_read", bus_if.avm_read, 1);
    check_eq("t4_flush_valid", bus_if.ins_valid, 0);
    run(2);
    bus_if.avm_waitrequest = 1'b0;
    tick();
    check_eq("t4_new_addr", bus_if.avm_address, 32'h200);
    n0 = n_cons;
    run(10);
    check_eq("t4_stale_acc", log_at(2), 32'h8);
    check_eq("t4_next_acc", log_at(3), 32'h200);
    check_eq("t4_progress", (n_cons - n0) >= 4, 1);

    // Low address bits ignored; fetch address wraps past 0xFFFF_FFFC.
    do_redirect(32'h0000_0203, 32'h0000_0200);
    check_eq("t5_align_addr", bus_if.avm_address, 32'h200);
    acc_log.delete();
    run(6);
    check_eq("t5_align_acc", log_at(0), 32'h200);
    do_redirect(32'hFFFF_FFFF, 32'hFFFF_FFFC);
    check_eq("t5_top_addr", bus_if.avm_address, 32'hFFFF_FFFC);
    acc_log.delete();
    n0 = n_cons;
    run(6);
    check_eq("t5_wrap_acc0", log_at(0), 32'hFFFF_FFFC);
    check_eq("t5_wrap_acc1", log_at(1), 32'h0);
    check_eq("t5_wrap_cons", (n_cons - n0) >= 3, 1);

    // Reset in the middle of a running burst.
    apply_reset();
    check_eq("t6_restart_read", bus_if.avm_read, 1);
    check_eq("t6_restart_addr", bus_if.avm_address, RESET_PC);
    n0 = n_cons;
    run(8);
    check_eq("t6_restart_acc", log_at(0), RESET_PC);
    check_eq("t6_progress", (n_cons - n0) >= 4, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
